// File: rtl/draw_cmd_arbiter.sv
// Two-requester round-robin arbiter for the VGA draw-engine command port.
// Each source has its own FIFO; two-word commands are issued without interleaving.
module draw_cmd_arbiter #(
  parameter int CMD_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic [CMD_WIDTH-1:0] cmd0,
  input  logic                 cmd0_vld,
  input  logic [CMD_WIDTH-1:0] cmd1,
  input  logic                 cmd1_vld,
  output logic [CMD_WIDTH-1:0] cmd_out,
  output logic                 cmd_out_vld,
  input  logic                 cmd_out_rdy,
  output logic                 cmd_out_src,
  output logic [1:0]           ovf,
  input  logic                 clr_ovf,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BURST0 = 2'd1;
  localparam logic [1:0] ST_BURST1 = 2'd2;

  // Line and character commands occupy two words; the head is marked by opcode and bit 0.
  function automatic logic is_pair_head(input logic [CMD_WIDTH-1:0] w);
    return ((w[CMD_WIDTH-1 -: 4] == 4'h9) || (w[CMD_WIDTH-1 -: 4] == 4'ha)) && (w[0] == 1'b0);
  endfunction

  logic [1:0]           vld_in_s;
  logic [1:0]           empty_s;
  logic [1:0]           full_s;
  logic [1:0]           push_s;
  logic [1:0]           pop_s;
  logic [1:0]           nxt_nonempty_s;
  logic [CMD_WIDTH-1:0] cmd_in_s [2];
  logic [CMD_WIDTH-1:0] head_s   [2];

  logic [1:0]           state_r, state_nxt_s;
  logic                 ptr_r, ptr_nxt_s;
  logic                 sel_s, sel_vld_s, load_s;
  logic [CMD_WIDTH-1:0] sel_word_s;
  logic                 out_vld_nxt_s;
  logic [1:0]           ovf_nxt_s;
  logic [CMD_WIDTH-1:0] cmd_out_r;
  logic                 out_vld_r, out_src_r, busy_r;
  logic [1:0]           ovf_r;

  assign vld_in_s    = {cmd1_vld, cmd0_vld};
  assign cmd_in_s[0] = cmd0;
  assign cmd_in_s[1] = cmd1;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [CMD_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [FIFO_AW:0]     wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;

    // The extra top pointer bit tells full from empty when the indices coincide.
    assign empty_s[g]        = (wr_ptr_r == rd_ptr_r);
    assign full_s[g]         = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                               (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    assign push_s[g]         = vld_in_s[g] && !full_s[g];
    assign head_s[g]         = mem_r[rd_ptr_r[FIFO_AW-1:0]];
    assign wr_nxt_s          = wr_ptr_r + {{FIFO_AW{1'b0}}, push_s[g]};
    assign rd_nxt_s          = rd_ptr_r + {{FIFO_AW{1'b0}}, pop_s[g]};
    assign nxt_nonempty_s[g] = (wr_nxt_s != rd_nxt_s);

    // FIFO read/write pointer registers
    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr_r <= {(FIFO_AW+1){1'b0}};
        rd_ptr_r <= {(FIFO_AW+1){1'b0}};
      end else begin
        wr_ptr_r <= wr_nxt_s;
        rd_ptr_r <= rd_nxt_s;
      end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
      if (push_s[g]) begin
        mem_r[wr_ptr_r[FIFO_AW-1:0]] <= cmd_in_s[g];
      end
    end
  end

  // Requester selection: round-robin when idle, locked to the owner during a pair
  always_comb begin
    sel_s     = 1'b0;
    sel_vld_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s[ptr_r]) begin
          sel_s     = ptr_r;
          sel_vld_s = 1'b1;
        end else if (!empty_s[ptr_r ^ 1'b1]) begin
          sel_s     = ptr_r ^ 1'b1;
          sel_vld_s = 1'b1;
        end else begin
          sel_s     = ptr_r;
          sel_vld_s = 1'b0;
        end
      end
      ST_BURST0: begin
        sel_s     = 1'b0;
        sel_vld_s = !empty_s[0];
      end
      ST_BURST1: begin
        sel_s     = 1'b1;
        sel_vld_s = !empty_s[1];
      end
      default: begin
        sel_s     = 1'b0;
        sel_vld_s = 1'b0;
      end
    endcase
  end

  assign load_s     = enb && (!out_vld_r || cmd_out_rdy) && sel_vld_s;
  assign pop_s      = load_s ? (2'b01 << sel_s) : 2'b00;
  assign sel_word_s = head_s[sel_s];

  // FSM and pointer advance on each load
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    if (load_s) begin
      case (state_r)
        ST_IDLE: begin
          if (is_pair_head(sel_word_s)) begin
            state_nxt_s = sel_s ? ST_BURST1 : ST_BURST0;
          end else begin
            ptr_nxt_s = sel_s ^ 1'b1;
          end
        end
        ST_BURST0, ST_BURST1: begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = sel_s ^ 1'b1;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else if (state_r == ST_BURST0 || state_r == ST_BURST1 || state_r == ST_IDLE) begin
      state_nxt_s = state_r;
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // Output valid and overflow next values; a new overflow beats a clear in the same cycle
  always_comb begin
    out_vld_nxt_s = out_vld_r;
    if (load_s) begin
      out_vld_nxt_s = 1'b1;
    end else if (out_vld_r && cmd_out_rdy) begin
      out_vld_nxt_s = 1'b0;
    end else begin
      out_vld_nxt_s = out_vld_r;
    end
    ovf_nxt_s = (clr_ovf ? 2'b00 : ovf_r) | (vld_in_s & full_s);
  end

  // Output register, FSM state, pointer and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= 1'b0;
      cmd_out_r <= {CMD_WIDTH{1'b0}};
      out_vld_r <= 1'b0;
      out_src_r <= 1'b0;
      ovf_r     <= 2'b00;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      out_vld_r <= out_vld_nxt_s;
      ovf_r     <= ovf_nxt_s;
      busy_r    <= (|nxt_nonempty_s) || out_vld_nxt_s;
      if (load_s) begin
        cmd_out_r <= sel_word_s;
        out_src_r <= sel_s;
      end
    end
  end

  assign cmd_out     = cmd_out_r;
  assign cmd_out_vld = out_vld_r;
  assign cmd_out_src = out_src_r;
  assign ovf         = ovf_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_draw_cmd_arbiter.sv
// Directed self-checking bench for draw_cmd_arbiter: latency, round-robin,
// atomic pairs, burst stall, overflow/clear, enable gating and reset mid-burst.
module tb_draw_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst, enb, cmd0_vld, cmd1_vld, cmd_out_rdy, clr_ovf;
  logic [31:0] cmd0, cmd1, cmd_out;
  logic        cmd_out_vld, cmd_out_src, busy;
  logic [1:0]  ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] got_w_q[$];
  logic        got_s_q[$];
  int          got_c_q[$];
  logic [31:0] exp_w_q[$];
  logic        exp_s_q[$];

  draw_cmd_arbiter #(.CMD_WIDTH(32), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .cmd0(cmd0), .cmd0_vld(cmd0_vld), .cmd1(cmd1), .cmd1_vld(cmd1_vld),
    .cmd_out(cmd_out), .cmd_out_vld(cmd_out_vld), .cmd_out_rdy(cmd_out_rdy),
    .cmd_out_src(cmd_out_src), .ovf(ovf), .clr_ovf(clr_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted word, sampled mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (rst && cmd_out_vld && cmd_out_rdy) begin
      got_w_q.push_back(cmd_out);
      got_s_q.push_back(cmd_out_src);
      got_c_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    cmd0_vld = v0; cmd0 = d0;
    cmd1_vld = v1; cmd1 = d1;
    step(1);
    cmd0_vld = 1'b0;
    cmd1_vld = 1'b0;
  endtask

  task automatic clear_q();
    got_w_q.delete(); got_s_q.delete(); got_c_q.delete();
    exp_w_q.delete(); exp_s_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    clear_q();
  endtask

  task automatic expect_word(input logic [31:0] w, input logic s);
    exp_w_q.push_back(w);
    exp_s_q.push_back(s);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, 32'(got_w_q.size()), 32'(exp_w_q.size()));
    for (int i = 0; i < exp_w_q.size() && i < got_w_q.size(); i++) begin
      chk($sformatf("%s_word%0d", tag, i), got_w_q[i], exp_w_q[i]);
      chk($sformatf("%s_src%0d", tag, i), {31'd0, got_s_q[i]}, {31'd0, exp_s_q[i]});
    end
  endtask

  initial begin
    rst = 1'b0; enb = 1'b1; cmd0_vld = 1'b0; cmd1_vld = 1'b0;
    cmd0 = 32'd0; cmd1 = 32'd0; cmd_out_rdy = 1'b1; clr_ovf = 1'b0;

    // reset state
    step(2);
    chk("rst_cmd_out", cmd_out, 32'd0);
    chk("rst_vld", {31'd0, cmd_out_vld}, 32'd0);
    chk("rst_src", {31'd0, cmd_out_src}, 32'd0);
    chk("rst_ovf", {30'd0, ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    step(1);

    // single request: valid two cycles after the write strobe
    push(1'b1, 32'h0A5F_3C00, 1'b0, 32'd0);
    chk("lat_vld_c1", {31'd0, cmd_out_vld}, 32'd0);
    chk("lat_busy_c1", {31'd0, busy}, 32'd1);
    step(1);
    chk("lat_vld_c2", {31'd0, cmd_out_vld}, 32'd1);
    chk("lat_word", cmd_out, 32'h0A5F_3C00);
    chk("lat_src", {31'd0, cmd_out_src}, 32'd0);
    step(1);
    chk("lat_busy_c3", {31'd0, busy}, 32'd0);
    chk("lat_vld_c3", {31'd0, cmd_out_vld}, 32'd0);

    // contention: alternate 0,1,0,1,0,1 back to back
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 32'h1000_0000 + 32'(i), 1'b1, 32'h2000_0000 + 32'(i));
      expect_word(32'h1000_0000 + 32'(i), 1'b0);
      expect_word(32'h2000_0000 + 32'(i), 1'b1);
    end
    step(8);
    check_seq("cont");
    for (int i = 1; i < got_c_q.size(); i++) begin
      chk($sformatf("cont_gap%0d", i), 32'(got_c_q[i] - got_c_q[i-1]), 32'd1);
    end

    // atomic pair on requester 1 with pointer at 1
    do_reset();
    push(1'b1, 32'h4000_0004, 1'b0, 32'd0);
    step(3);
    clear_q();
    push(1'b0, 32'd0, 1'b1, 32'hA123_4560);
    push(1'b1, 32'h2000_00AA, 1'b0, 32'd0);
    push(1'b0, 32'd0, 1'b1, 32'hA000_0001);
    expect_word(32'hA123_4560, 1'b1);
    expect_word(32'hA000_0001, 1'b1);
    expect_word(32'h2000_00AA, 1'b0);
    step(6);
    check_seq("pair");

    // burst stall: requester 1 waits for the tail of requester 0
    do_reset();
    push(1'b1, 32'h9000_0010, 1'b0, 32'd0);
    push(1'b0, 32'd0, 1'b1, 32'h3000_0001);
    push(1'b0, 32'd0, 1'b1, 32'h3000_0002);
    step(1);
    chk("stall_vld", {31'd0, cmd_out_vld}, 32'd0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    step(1);
    push(1'b1, 32'h9000_0011, 1'b0, 32'd0);
    expect_word(32'h9000_0010, 1'b0);
    expect_word(32'h9000_0011, 1'b0);
    expect_word(32'h3000_0001, 1'b1);
    expect_word(32'h3000_0002, 1'b1);
    step(8);
    check_seq("stall");

    // backpressure and overflow: 1 in output + 16 in FIFO, further words dropped
    do_reset();
    cmd_out_rdy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(1'b1, 32'h1000_0100 + 32'(i), 1'b0, 32'd0);
      expect_word(32'h1000_0100 + 32'(i), 1'b0);
    end
    chk("ovf_before", {30'd0, ovf}, 32'd0);
    push(1'b1, 32'h1EAD_0017, 1'b0, 32'd0);
    chk("ovf_set", {30'd0, ovf}, 32'd1);
    chk("ovf_hold_word", cmd_out, 32'h1000_0100);
    chk("ovf_hold_vld", {31'd0, cmd_out_vld}, 32'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("ovf_clr", {30'd0, ovf}, 32'd0);
    clr_ovf = 1'b1;
    push(1'b1, 32'h1EAD_0018, 1'b0, 32'd0);
    clr_ovf = 1'b0;
    chk("ovf_set_wins", {30'd0, ovf}, 32'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("ovf_clr2", {30'd0, ovf}, 32'd0);
    cmd_out_rdy = 1'b1;
    step(20);
    check_seq("ovf_drain");
    chk("ovf_drain_busy", {31'd0, busy}, 32'd0);

    // enable low holds off the first load
    do_reset();
    enb = 1'b0;
    push(1'b1, 32'h7000_0007, 1'b0, 32'd0);
    step(2);
    chk("enb_vld", {31'd0, cmd_out_vld}, 32'd0);
    chk("enb_busy", {31'd0, busy}, 32'd1);
    enb = 1'b1;
    step(1);
    chk("enb_load_vld", {31'd0, cmd_out_vld}, 32'd1);
    chk("enb_load_word", cmd_out, 32'h7000_0007);
    step(2);

    // reset in the middle of a burst with both FIFOs occupied
    do_reset();
    cmd_out_rdy = 1'b0;
    push(1'b1, 32'h9000_0020, 1'b0, 32'd0);
    push(1'b1, 32'h6000_0006, 1'b1, 32'h6100_0006);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk("rstb_vld", {31'd0, cmd_out_vld}, 32'd0);
    chk("rstb_busy", {31'd0, busy}, 32'd0);
    chk("rstb_ovf", {30'd0, ovf}, 32'd0);
    cmd_out_rdy = 1'b1;
    push(1'b0, 32'd0, 1'b1, 32'h5000_0005);
    step(1);
    chk("rstb_new_vld", {31'd0, cmd_out_vld}, 32'd1);
    chk("rstb_new_word", cmd_out, 32'h5000_0005);
    chk("rstb_new_src", {31'd0, cmd_out_src}, 32'd1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
